// File: rtl/cv32e40p_tmr_voter_mon.sv
// Registered TMR voter with per-replica consecutive-mismatch monitoring.
// Degrades TMR -> DMR on one permanent fault and to FAIL on further disagreement.
//
// state     | meaning
// MODE_TMR  | all three replicas healthy, majority vote, counters active
// MODE_DMR  | exactly one replica masked, duplex compare of the other two
// MODE_FAIL | output unreliable until clear_i
module cv32e40p_tmr_voter_mon #(
    parameter  int NBIT   = 32,
    parameter  int THRESH = 4,
    localparam int CNT_W  = $clog2(THRESH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [NBIT-1:0] data1_i,
    input  logic [NBIT-1:0] data2_i,
    input  logic [NBIT-1:0] data3_i,
    input  logic            clear_i,
    output logic            valid_o,
    output logic [NBIT-1:0] dataout_o,
    output logic            error_detected_input_a_o,
    output logic            error_detected_input_b_o,
    output logic            error_detected_input_c_o,
    output logic            uncorrectable_o,
    output logic [2:0]      fault_o,
    output logic [1:0]      mode_o
);

    localparam logic [1:0] MODE_TMR  = 2'd0;
    localparam logic [1:0] MODE_DMR  = 2'd1;
    localparam logic [1:0] MODE_FAIL = 2'd2;

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    logic                  valid_q, valid_d;
    logic [NBIT-1:0]       data_q, data_d;
    logic [2:0]            flag_q, flag_d;
    logic                  unc_q, unc_d;
    logic [2:0]            fault_q, fault_d;
    logic [1:0]            mode_q, mode_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    logic            eq_ab, eq_bc, eq_ac;
    logic [2:0]      tmr_flag;
    logic [NBIT-1:0] tmr_out;
    logic            tmr_unc;
    logic [2:0]      new_fault;
    logic [1:0]      n_new;
    logic [NBIT-1:0] dmr_p, dmr_q;
    logic [2:0]      dmr_mask;

    assign eq_ab = (data1_i == data2_i);
    assign eq_bc = (data2_i == data3_i);
    assign eq_ac = (data1_i == data3_i);

    // Majority vote in fixed priority; flags are {C,B,A}.
    always_comb begin
        tmr_out  = data1_i;
        tmr_flag = 3'b000;
        tmr_unc  = 1'b0;
        if (eq_bc) begin
            tmr_out  = data2_i;
            tmr_flag = {2'b00, !eq_ab};
        end else if (eq_ab) begin
            tmr_flag = 3'b100;
        end else if (eq_ac) begin
            tmr_flag = 3'b010;
        end else begin
            tmr_flag = 3'b111;
            tmr_unc  = 1'b1;
        end
    end

    // Healthy pair in DMR, lower index first.
    always_comb begin
        dmr_p    = data1_i;
        dmr_q    = data2_i;
        dmr_mask = 3'b011;
        case (fault_q)
            3'b001: begin
                dmr_p    = data2_i;
                dmr_q    = data3_i;
                dmr_mask = 3'b110;
            end
            3'b010: begin
                dmr_q    = data3_i;
                dmr_mask = 3'b101;
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d   = valid_i;
        data_d    = data_q;
        flag_d    = flag_q;
        unc_d     = unc_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        mode_d    = mode_q;
        new_fault = 3'b000;
        n_new     = 2'd0;
        if (valid_i) begin
            case (mode_q)
                MODE_TMR: begin
                    data_d = tmr_out;
                    flag_d = tmr_flag;
                    unc_d  = tmr_unc;
                    for (int i = 0; i < 3; i++) begin
                        if (tmr_flag[i]) begin
                            cnt_d[i] = (cnt_q[i] == THR) ? THR : cnt_q[i] + 1'b1;
                        end else begin
                            cnt_d[i] = '0;
                        end
                        new_fault[i] = (cnt_d[i] == THR);
                    end
                    n_new   = {1'b0, new_fault[0]} + {1'b0, new_fault[1]} + {1'b0, new_fault[2]};
                    fault_d = fault_q | new_fault;
                    if (n_new == 2'd1) begin
                        mode_d = MODE_DMR;
                    end else if (n_new != 2'd0) begin
                        mode_d = MODE_FAIL;
                    end
                end
                MODE_DMR: begin
                    data_d = dmr_p;
                    if (dmr_p == dmr_q) begin
                        flag_d = 3'b000;
                        unc_d  = 1'b0;
                    end else begin
                        flag_d = dmr_mask;
                        unc_d  = 1'b1;
                        mode_d = MODE_FAIL;
                    end
                end
                default: begin
                    if (!fault_q[0]) begin
                        data_d = data1_i;
                    end else if (!fault_q[1]) begin
                        data_d = data2_i;
                    end else if (!fault_q[2]) begin
                        data_d = data3_i;
                    end else begin
                        data_d = data1_i;
                    end
                    flag_d = tmr_flag;
                    unc_d  = 1'b1;
                end
            endcase
        end
        // The vote above still uses the pre-clear mode; only its bookkeeping is dropped.
        if (clear_i) begin
            cnt_d   = '0;
            fault_d = 3'b000;
            mode_d  = MODE_TMR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            flag_q  <= 3'b000;
            unc_q   <= 1'b0;
            cnt_q   <= '0;
            fault_q <= 3'b000;
            mode_q  <= MODE_TMR;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            unc_q   <= unc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            mode_q  <= mode_d;
        end
    end

    assign valid_o                  = valid_q;
    assign dataout_o                = data_q;
    assign error_detected_input_a_o = flag_q[0];
    assign error_detected_input_b_o = flag_q[1];
    assign error_detected_input_c_o = flag_q[2];
    assign uncorrectable_o          = unc_q;
    assign fault_o                  = fault_q;
    assign mode_o                   = mode_q;

endmodule

// File: tb/tb_cv32e40p_tmr_voter_mon.sv
// Directed bench for the TMR voter monitor; three instances (THRESH 4, 2, 1)
// share one stimulus stream and are reset between scenarios.
module tb_cv32e40p_tmr_voter_mon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] d1 = '0, d2 = '0, d3 = '0;

    logic        vo4, ea4, eb4, ec4, unc4;
    logic [31:0] do4;
    logic [2:0]  f4;
    logic [1:0]  m4;
    logic        vo2, ea2, eb2, ec2, unc2;
    logic [31:0] do2;
    logic [2:0]  f2;
    logic [1:0]  m2;
    logic        vo1, ea1, eb1, ec1, unc1;
    logic [31:0] do1;
    logic [2:0]  f1;
    logic [1:0]  m1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cv32e40p_tmr_voter_mon #(.NBIT(32), .THRESH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid),
        .data1_i(d1), .data2_i(d2), .data3_i(d3), .clear_i(clr),
        .valid_o(vo4), .dataout_o(do4),
        .error_detected_input_a_o(ea4), .error_detected_input_b_o(eb4),
        .error_detected_input_c_o(ec4), .uncorrectable_o(unc4),
        .fault_o(f4), .mode_o(m4)
    );

    cv32e40p_tmr_voter_mon #(.NBIT(32), .THRESH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid),
        .data1_i(d1), .data2_i(d2), .data3_i(d3), .clear_i(clr),
        .valid_o(vo2), .dataout_o(do2),
        .error_detected_input_a_o(ea2), .error_detected_input_b_o(eb2),
        .error_detected_input_c_o(ec2), .uncorrectable_o(unc2),
        .fault_o(f2), .mode_o(m2)
    );

    cv32e40p_tmr_voter_mon #(.NBIT(32), .THRESH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid),
        .data1_i(d1), .data2_i(d2), .data3_i(d3), .clear_i(clr),
        .valid_o(vo1), .dataout_o(do1),
        .error_detected_input_a_o(ea1), .error_detected_input_b_o(eb1),
        .error_detected_input_c_o(ec1), .uncorrectable_o(unc1),
        .fault_o(f1), .mode_o(m1)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // flags are {C,B,A}
    task automatic exp4(input string tag, input logic [31:0] d, input logic [2:0] fl,
                        input logic u, input logic [1:0] m, input logic [2:0] f);
        chk({tag, ".valid"}, 64'(vo4), 64'(1'b1));
        chk({tag, ".data"}, 64'(do4), 64'(d));
        chk({tag, ".flags"}, 64'({ec4, eb4, ea4}), 64'(fl));
        chk({tag, ".unc"}, 64'(unc4), 64'(u));
        chk({tag, ".mode"}, 64'(m4), 64'(m));
        chk({tag, ".fault"}, 64'(f4), 64'(f));
    endtask

    task automatic vote(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        d1 = a;
        d2 = b;
        d3 = c;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.valid", 64'(vo4), 64'(1'b0));
        chk("rst.data", 64'(do4), 64'h0);
        chk("rst.unc", 64'(unc4), 64'(1'b0));
        chk("rst.mode", 64'(m4), 64'(2'd0));
        chk("rst.fault", 64'(f4), 64'(3'b000));

        for (int i = 0; i < 3; i++) begin
            vote(32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
            exp4($sformatf("agree%0d", i), 32'h1234_5678, 3'b000, 1'b0, 2'd0, 3'b000);
        end

        // A wrong four times in a row -> A faulty, DMR
        for (int i = 0; i < 4; i++) begin
            vote(32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_FFFF);
            if (i < 3) exp4($sformatf("flagA%0d", i), 32'h0000_FFFF, 3'b001, 1'b0, 2'd0, 3'b000);
            else       exp4("flagA3", 32'h0000_FFFF, 3'b001, 1'b0, 2'd1, 3'b001);
        end
        vote(32'hDEAD_BEEF, 32'h5, 32'h5);
        exp4("dmr_eq", 32'h5, 3'b000, 1'b0, 2'd1, 3'b001);

        d1 = 32'h9; d2 = 32'h9; d3 = 32'h9;
        @(posedge clk);
        #1;
        chk("idle.valid", 64'(vo4), 64'(1'b0));
        chk("idle.data", 64'(do4), 64'h5);
        chk("idle.mode", 64'(m4), 64'(2'd1));

        vote(32'h0, 32'h1, 32'h2);
        exp4("dmr_ne", 32'h1, 3'b110, 1'b1, 2'd2, 3'b001);
        vote(32'h9, 32'h7, 32'h7);
        exp4("fail_vote", 32'h7, 3'b001, 1'b1, 2'd2, 3'b001);

        clr = 1'b1;
        vote(32'h1, 32'h1, 32'h1);
        clr = 1'b0;
        exp4("clear_vote", 32'h1, 3'b000, 1'b1, 2'd0, 3'b000);
        vote(32'h3, 32'h3, 32'h3);
        exp4("post_clear", 32'h3, 3'b000, 1'b0, 2'd0, 3'b000);

        // Clean vote in between restarts the consecutive count
        for (int i = 0; i < 3; i++) vote(32'h1, 32'h2, 32'h2);
        vote(32'h2, 32'h2, 32'h2);
        for (int i = 0; i < 3; i++) vote(32'h1, 32'h2, 32'h2);
        exp4("restart", 32'h2, 3'b001, 1'b0, 2'd0, 3'b000);
        vote(32'h1, 32'h2, 32'h2);
        exp4("restart_4th", 32'h2, 3'b001, 1'b0, 2'd1, 3'b001);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            vote(32'h1, 32'h2, 32'h3);
            chk($sformatf("t2.data%0d", i), 64'(do2), 64'h1);
            chk($sformatf("t2.flags%0d", i), 64'({ec2, eb2, ea2}), 64'(3'b111));
            chk($sformatf("t2.unc%0d", i), 64'(unc2), 64'(1'b1));
            chk($sformatf("t2.mode%0d", i), 64'(m2), i == 0 ? 64'(2'd0) : 64'(2'd2));
            chk($sformatf("t2.fault%0d", i), 64'(f2), i == 0 ? 64'(3'b000) : 64'(3'b111));
        end

        do_reset();
        vote(32'h1, 32'h2, 32'h2);
        chk("t1.data", 64'(do1), 64'h2);
        chk("t1.flags", 64'({ec1, eb1, ea1}), 64'(3'b001));
        chk("t1.fault", 64'(f1), 64'(3'b001));
        chk("t1.mode", 64'(m1), 64'(2'd1));
        exp4("t4_same", 32'h2, 3'b001, 1'b0, 2'd0, 3'b000);

        do_reset();
        vote(32'h2, 32'h1, 32'h2);
        chk("t1b.fault", 64'(f1), 64'(3'b010));
        vote(32'h4, 32'h0, 32'h5);
        chk("t1b.data", 64'(do1), 64'h4);
        chk("t1b.flags", 64'({ec1, eb1, ea1}), 64'(3'b101));
        chk("t1b.unc", 64'(unc1), 64'(1'b1));
        chk("t1b.mode", 64'(m1), 64'(2'd2));

        vote(32'h7, 32'h7, 32'h7);
        exp4("pre_rst", 32'h7, 3'b000, 1'b0, 2'd0, 3'b000);
        rst = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = 1'b0;
        chk("mid_rst.valid", 64'(vo4), 64'(1'b0));
        chk("mid_rst.data", 64'(do4), 64'h0);
        chk("mid_rst.fault1", 64'(f1), 64'(3'b000));
        chk("mid_rst.mode1", 64'(m1), 64'(2'd0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
